i2c_scl_timer: RTL and testbench
================================

// Module: i2c_scl_timer
// PURPOSE
//  Generates the I2C master SCL waveform from clk via a quarter-period divider.
//  Honours slave clock stretching and times out a stuck SCL.
//  Emits one-cycle phase strobes to the downstream bit/byte counter stage:
//  - tick_change: SDA may change.
//  - tick_sample: SDA is sampled.
//  - tick_fall: bit complete.
//  - stretching: the counter stage holds while asserted.
// PARAMETERS
//  QUARTER  125    clk cycles per quarter SCL period (50 MHz -> 100 kHz)
//  CNT_W    16     width of phase and timeout counters; QUARTER, TIMEOUT < 2**CNT_W
//  TIMEOUT  50000  max clk cycles in WAIT_HIGH before abort
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  reset        in   1  synchronous, active-high
//  enable       in   1  level; 1 = run SCL bits, 0 = finish current bit then idle
//  scl_in       in   1  raw SCL pad input, asynchronous; 2-flop synchronised inside
//  scl_oe       out  1  1 = drive SCL low, 0 = release (open-drain)
//  tick_change  out  1  pulse, middle of SCL low
//  tick_rise    out  1  pulse, synchronised SCL seen high after release
//  tick_sample  out  1  pulse, middle of SCL high
//  tick_fall    out  1  pulse, end of SCL high (bit done)
//  stretching   out  1  level, slave holding SCL low
//  timeout      out  1  pulse, stretch exceeded TIMEOUT
//  busy         out  1  level, state != IDLE
// BEHAVIOUR
//  Reset (sync, wins over all inputs):
//  - state=IDLE; scl_oe, all ticks, stretching, timeout, busy = 0.
//  - Sync flops = 1; counters = 0.
//  - Reset mid-operation releases SCL on that same edge.
//  Phase counter: cnt counts 0..QUARTER-1; terminal at QUARTER-1; cleared on every state change.
//  States and transitions:
//  - IDLE: scl_oe=0. When enable=1, go to LOW1 next edge (scl_oe=1 one cycle after enable).
//  - LOW1: scl_oe=1. At terminal, pulse tick_change and go to LOW2.
//  - LOW2: scl_oe=1. At terminal, go to WAIT_HIGH with scl_oe=0.
//  - WAIT_HIGH: scl_oe=0; wait_cnt increments each cycle.
//    - If scl_sync==1: pulse tick_rise, go to HIGH1.
//    - Else if wait_cnt==TIMEOUT-1: pulse timeout, go to IDLE.
//  - HIGH1: at terminal, pulse tick_sample and go to HIGH2.
//  - HIGH2: at terminal, pulse tick_fall.
//    - If enable: go to LOW1 (scl_oe=1).
//    - Else: go to IDLE.
//  stretching: asserted in WAIT_HIGH once wait_cnt>=3 and scl_sync==0; cleared on leaving WAIT_HIGH.
//  - With zero-delay loopback, WAIT_HIGH dwell is exactly 2 cycles and stretching never asserts.
//  Clock sync: scl_sync==0 in HIGH1/HIGH2 means another device pulled SCL low.
//  - Go to LOW1 immediately; no tick_sample/tick_fall for that bit.
//  Simultaneous-event priority:
//  - scl_sync high and timeout in the same cycle: rise wins, no timeout.
//  - enable drop in any non-IDLE state: the bit completes through HIGH2, including tick_fall.
//  - enable re-raised before HIGH2 terminal: treated as continuous.
//  Ticks: mutually exclusive, single-cycle, registered, asserted in the cycle the new state is entered.
//  Loopback SCL period = 4*QUARTER+2 cycles.
// STRUCTURE
//  Shared include i2c_defs.vh holds:
//  - state encodings (IDLE=0, LOW1, LOW2, WAIT_HIGH, HIGH1, HIGH2; 3 bits);
//  - default QUARTER and TIMEOUT;
//  - SYNC_STAGES=2.
//  Sub-module i2c_sync2: 2-flop synchroniser, reset value 1; reusable for SDA.
//  Everything else (FSM, phase counter, wait counter, tick regs) lives in this file.
// TESTING  (QUARTER=4, TIMEOUT=40; scl_in = ~scl_oe unless stated)
//  1 Reset, then enable=1 for 3 bits:
//    - scl_oe rises 1 cycle after enable; per-bit tick order is change, rise, sample, fall;
//    - period 18 cycles; busy=1 throughout.
//  2 Force scl_in=0 for 20 cycles after release:
//    - stretching=1 from dwell cycle 3;
//    - tick_rise 2 cycles after scl_in releases; no timeout.
//  3 Force scl_in=0 for 60 cycles:
//    - timeout pulses once at dwell 40; next edge scl_oe=0, busy=0, state IDLE.
//  4 Drop enable in the middle of LOW1:
//    - exactly one more tick_fall, then IDLE with SCL released;
//    - no further ticks while enable=0.
//  5 Assert reset 1 cycle in HIGH1:
//    - next edge scl_oe=0, all outputs 0;
//    - restart on enable behaves as in test 1.
//  6 Pull scl_in low 2 cycles into HIGH1:
//    - LOW1 entered once sync propagates; scl_oe=1;
//    - no tick_sample or tick_fall for that bit.

Source files
------------

// File: rtl/i2c_scl_timer_pkg.sv
// -----------------------------------------------------------------------------
// i2c_scl_timer_pkg : shared state encoding and defaults for the SCL timer
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package i2c_scl_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOW1      = 3'd1,
      ST_LOW2      = 3'd2,
      ST_WAIT_HIGH = 3'd3,
      ST_HIGH1     = 3'd4,
      ST_HIGH2     = 3'd5
   } state_e;

   localparam int DEFAULT_QUARTER = 125;
   localparam int DEFAULT_TIMEOUT = 50000;
   localparam int SYNC_STAGES     = 2;

   // States whose duration is set by the quarter-period phase counter.
   function automatic logic is_timed(state_e s);
      return (s == ST_LOW1) || (s == ST_LOW2) || (s == ST_HIGH1) || (s == ST_HIGH2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_sync2.sv
// -----------------------------------------------------------------------------
// i2c_sync2 : multi-flop synchroniser for open-drain pad inputs, idles high
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module i2c_sync2
   import i2c_scl_timer_pkg::*;
#(
   parameter int   STAGES    = SYNC_STAGES,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/i2c_scl_timer.sv
// -----------------------------------------------------------------------------
// i2c_scl_timer : I2C master SCL generator with stretching, clock sync, timeout
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module i2c_scl_timer
   import i2c_scl_timer_pkg::*;
#(
   parameter int QUARTER = DEFAULT_QUARTER,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic scl_in,
   output logic scl_oe,
   output logic tick_change,
   output logic tick_rise,
   output logic tick_sample,
   output logic tick_fall,
   output logic stretching,
   output logic timeout,
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(QUARTER - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STRETCH_MIN = CNT_W'(3);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             scl_oe_q, scl_oe_d;
   logic             tick_change_q, tick_change_d;
   logic             tick_rise_q, tick_rise_d;
   logic             tick_sample_q, tick_sample_d;
   logic             tick_fall_q, tick_fall_d;
   logic             timeout_q, timeout_d;
   logic             scl_sync;
   logic             cnt_last;

   i2c_sync2 #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_scl_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (scl_in),
      .q_o   (scl_sync)
   );

   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d       = state_q;
      tick_change_d = 1'b0;
      tick_rise_d   = 1'b0;
      tick_sample_d = 1'b0;
      tick_fall_d   = 1'b0;
      timeout_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_LOW1;
         end
         ST_LOW1: begin
            if (cnt_last) begin
               state_d       = ST_LOW2;
               tick_change_d = 1'b1;
            end
         end
         ST_LOW2: begin
            if (cnt_last) state_d = ST_WAIT_HIGH;
         end
         ST_WAIT_HIGH: begin
            // A rise seen on the last allowed cycle still counts as a rise.
            if (scl_sync) begin
               state_d     = ST_HIGH1;
               tick_rise_d = 1'b1;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end
         end
         ST_HIGH1: begin
            if (!scl_sync) begin
               state_d = ST_LOW1;
            end else if (cnt_last) begin
               state_d       = ST_HIGH2;
               tick_sample_d = 1'b1;
            end
         end
         ST_HIGH2: begin
            if (!scl_sync) begin
               state_d = ST_LOW1;
            end else if (cnt_last) begin
               state_d     = enable ? ST_LOW1 : ST_IDLE;
               tick_fall_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      cnt_d      = ((state_d == state_q) && is_timed(state_q)) ? cnt_q + 1'b1 : '0;
      wait_cnt_d = ((state_d == ST_WAIT_HIGH) && (state_q == ST_WAIT_HIGH)) ? wait_cnt_q + 1'b1 : '0;

      // SCL is released during the final LOW2 cycle so the synchroniser latency
      // overlaps the low phase and a loopback bit takes 4*QUARTER+2 cycles.
      scl_oe_d = (state_d == ST_LOW1) || ((state_d == ST_LOW2) && (cnt_d != CNT_LAST));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         wait_cnt_q    <= '0;
         scl_oe_q      <= 1'b0;
         tick_change_q <= 1'b0;
         tick_rise_q   <= 1'b0;
         tick_sample_q <= 1'b0;
         tick_fall_q   <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         scl_oe_q      <= scl_oe_d;
         tick_change_q <= tick_change_d;
         tick_rise_q   <= tick_rise_d;
         tick_sample_q <= tick_sample_d;
         tick_fall_q   <= tick_fall_d;
         timeout_q     <= timeout_d;
      end
   end

   assign scl_oe      = scl_oe_q;
   assign tick_change = tick_change_q;
   assign tick_rise   = tick_rise_q;
   assign tick_sample = tick_sample_q;
   assign tick_fall   = tick_fall_q;
   assign timeout     = timeout_q;
   assign busy        = (state_q != ST_IDLE);
   assign stretching  = (state_q == ST_WAIT_HIGH) && (wait_cnt_q >= STRETCH_MIN) && !scl_sync;

endmodule

`default_nettype wire

// File: tb/tb_i2c_scl_timer.sv
// -----------------------------------------------------------------------------
// tb_i2c_scl_timer : directed bench with a cycle-level behavioural SCL model
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_i2c_scl_timer;

   localparam int Q = 4;
   localparam int T = 40;

   localparam int P_IDLE  = 0;
   localparam int P_LOW1  = 1;
   localparam int P_LOW2  = 2;
   localparam int P_WAIT  = 3;
   localparam int P_HIGH1 = 4;
   localparam int P_HIGH2 = 5;

   localparam int S_OE     = 0;
   localparam int S_CHANGE = 1;
   localparam int S_RISE   = 2;
   localparam int S_SAMPLE = 3;
   localparam int S_FALL   = 4;
   localparam int S_TO     = 5;
   localparam int S_OE_LOW = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic force_low = 1'b0;
   logic scl_in;
   logic scl_oe, tick_change, tick_rise, tick_sample, tick_fall, stretching, timeout, busy;

   int checks = 0;
   int failures = 0;
   int n_chg = 0, n_rise = 0, n_smp = 0, n_fall = 0, n_to = 0, n_str = 0;

   // Behavioural model: phase, cycles left in a timed phase, dwell in WAIT_HIGH,
   // and the two most recent SCL samples (h2 is what the design acts on).
   int m_ph = P_IDLE, m_rem = 0, m_dw = 0;
   bit m_h1 = 1'b1, m_h2 = 1'b1;
   bit m_oe = 1'b0, m_tc = 1'b0, m_tr = 1'b0, m_ts = 1'b0, m_tf = 1'b0, m_to = 1'b0;

   assign scl_in = ~scl_oe & ~force_low;

   always #5 clk = ~clk;

   i2c_scl_timer #(
      .QUARTER (Q),
      .CNT_W   (16),
      .TIMEOUT (T)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .scl_in      (scl_in),
      .scl_oe      (scl_oe),
      .tick_change (tick_change),
      .tick_rise   (tick_rise),
      .tick_sample (tick_sample),
      .tick_fall   (tick_fall),
      .stretching  (stretching),
      .timeout     (timeout),
      .busy        (busy)
   );

   function automatic logic [7:0] dut_vec();
      return {scl_oe, tick_change, tick_rise, tick_sample, tick_fall, stretching, timeout, busy};
   endfunction

   function automatic logic sig(input int sel);
      case (sel)
         S_OE:     return scl_oe;
         S_CHANGE: return tick_change;
         S_RISE:   return tick_rise;
         S_SAMPLE: return tick_sample;
         S_FALL:   return tick_fall;
         S_TO:     return timeout;
         default:  return !scl_oe;
      endcase
   endfunction

   task automatic enter(input int p);
      m_ph  = p;
      m_rem = Q;
      m_dw  = 0;
   endtask

   task automatic model_adv();
      bit sin, sync;
      m_tc = 0; m_tr = 0; m_ts = 0; m_tf = 0; m_to = 0;
      if (reset) begin
         m_ph = P_IDLE; m_rem = 0; m_dw = 0; m_h1 = 1; m_h2 = 1; m_oe = 0;
         return;
      end
      sin  = !m_oe && !force_low;
      sync = m_h2;
      m_h2 = m_h1;
      m_h1 = sin;
      case (m_ph)
         P_IDLE:  if (enable) enter(P_LOW1);
         P_LOW1:  if (m_rem == 1) begin m_tc = 1; enter(P_LOW2); end else m_rem--;
         P_LOW2:  if (m_rem == 1) enter(P_WAIT); else m_rem--;
         P_WAIT: begin
            if (sync) begin m_tr = 1; enter(P_HIGH1); end
            else if (m_dw == T - 1) begin m_to = 1; enter(P_IDLE); end
            else m_dw++;
         end
         P_HIGH1: begin
            if (!sync) enter(P_LOW1);
            else if (m_rem == 1) begin m_ts = 1; enter(P_HIGH2); end
            else m_rem--;
         end
         default: begin
            if (!sync) enter(P_LOW1);
            else if (m_rem == 1) begin m_tf = 1; enter(enable ? P_LOW1 : P_IDLE); end
            else m_rem--;
         end
      endcase
      m_oe = (m_ph == P_LOW1) || (m_ph == P_LOW2 && m_rem > 1);
   endtask

   // One clock: advance the model over the coming edge, then compare at negedge.
   task automatic step();
      logic [7:0] exp_v;
      model_adv();
      @(negedge clk);
      exp_v = {m_oe, m_tc, m_tr, m_ts, m_tf,
               (m_ph == P_WAIT) && (m_dw >= 3) && !m_h2, m_to, m_ph != P_IDLE};
      checks++;
      if (dut_vec() !== exp_v) begin
         failures++;
         $display("FAIL cycle_compare t=%0t actual=%b expected=%b (oe,chg,rise,smp,fall,str,to,busy)",
                  $time, dut_vec(), exp_v);
      end
      n_chg  += int'(tick_change);
      n_rise += int'(tick_rise);
      n_smp  += int'(tick_sample);
      n_fall += int'(tick_fall);
      n_to   += int'(timeout);
      n_str  += int'(stretching);
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   task automatic wait_for(input int sel, input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!sig(sel) && n < budget);
      if (!sig(sel)) begin
         checks++;
         failures++;
         $display("FAIL wait_sel%0d actual=timeout_after_%0d expected=event", sel, n);
      end
   endtask

   initial begin
      int n, snap_a, snap_b;

      // Reset
      repeat (3) step();
      chk("reset_outputs", int'(dut_vec()), 0);
      reset = 1'b0;
      step();

      // Continuous run, three bits
      enable = 1'b1;
      wait_for(S_OE, 5, n);       chk("oe_after_enable", n, 1);
      chk("busy_running", int'(busy), 1);
      wait_for(S_CHANGE, 30, n);  chk("lat_change", n, 4);
      wait_for(S_RISE, 30, n);    chk("lat_rise", n, 6);
      wait_for(S_SAMPLE, 30, n);  chk("lat_sample", n, 4);
      wait_for(S_FALL, 30, n);    chk("lat_fall", n, 4);
      wait_for(S_FALL, 40, n);    chk("period_bit2", n, 18);
      wait_for(S_FALL, 40, n);    chk("period_bit3", n, 18);

      // Enable dropped mid-LOW1: bit completes, then idle
      step(); step();
      enable = 1'b0;
      wait_for(S_FALL, 40, n);    chk("drop_fall_lat", n, 16);
      chk("drop_idle_busy", int'(busy), 0);
      chk("drop_idle_oe", int'(scl_oe), 0);
      snap_a = n_chg + n_rise + n_smp + n_fall + n_to;
      repeat (30) step();
      chk("idle_no_ticks", n_chg + n_rise + n_smp + n_fall + n_to - snap_a, 0);

      // Stretch for 20 cycles after release
      enable = 1'b1;
      wait_for(S_CHANGE, 30, n);
      enable = 1'b0;
      force_low = 1'b1;
      wait_for(S_OE_LOW, 10, n);  chk("release_lat", n, 3);
      snap_a = n_str;
      snap_b = n_to;
      repeat (20) step();
      force_low = 1'b0;
      wait_for(S_RISE, 20, n);    chk("stretch_rise_lat", n, 3);
      chk("stretch_cycles", n_str - snap_a, 18);
      chk("stretch_no_timeout", n_to - snap_b, 0);
      wait_for(S_FALL, 20, n);    chk("stretch_fall_lat", n, 8);
      chk("stretch_end_busy", int'(busy), 0);

      // Stuck low: timeout
      enable = 1'b1;
      wait_for(S_CHANGE, 30, n);
      enable = 1'b0;
      force_low = 1'b1;
      wait_for(S_OE_LOW, 10, n);
      snap_b = n_to;
      wait_for(S_TO, 80, n);      chk("timeout_lat", n, 41);
      chk("timeout_busy", int'(busy), 0);
      chk("timeout_oe", int'(scl_oe), 0);
      repeat (20) step();
      force_low = 1'b0;
      repeat (4) step();
      chk("timeout_once", n_to - snap_b, 1);

      // Reset during HIGH1, then restart
      enable = 1'b1;
      wait_for(S_RISE, 40, n);
      reset = 1'b1;
      step();
      chk("midrun_reset_outputs", int'(dut_vec()), 0);
      reset = 1'b0;
      wait_for(S_OE, 5, n);       chk("restart_oe", n, 1);
      wait_for(S_CHANGE, 30, n);  chk("restart_change", n, 4);
      wait_for(S_RISE, 30, n);    chk("restart_rise", n, 6);

      // Another master pulls SCL low in HIGH1
      step();
      force_low = 1'b1;
      snap_a = n_smp + n_fall;
      wait_for(S_OE, 10, n);      chk("csync_low1_lat", n, 3);
      chk("csync_no_sample_fall", n_smp + n_fall - snap_a, 0);
      step(); step();
      force_low = 1'b0;
      enable = 1'b0;
      wait_for(S_FALL, 40, n);    chk("csync_next_fall", n, 16);
      chk("csync_end_busy", int'(busy), 0);
      repeat (5) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
